// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and one slave.
// Master-side signals are indexed by master number.
interface wb_rr_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 8
);
  logic [1:0]    m_cyc;
  logic [1:0]    m_stb;
  logic [1:0]    m_we;
  logic [AW-1:0] m_adr  [2];
  logic [DW-1:0] m_wdat [2];
  logic [2:0]    m_cti  [2];
  logic [1:0]    m_bte  [2];
  logic [1:0]    m_ack;
  logic [1:0]    m_err;
  logic [1:0]    m_rty;
  logic [DW-1:0] m_rdat [2];

  logic          s_cyc;
  logic          s_stb;
  logic          s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack;
  logic          s_err;
  logic          s_rty;
  logic [DW-1:0] s_rdat;

  modport arb (
    input  m_cyc, m_stb, m_we, m_adr,
    input  m_wdat, m_cti, m_bte,
    output m_ack, m_err, m_rty, m_rdat,
    output s_cyc, s_stb, s_we, s_adr,
    output s_wdat, s_cti, s_bte,
    input  s_ack, s_err, s_rty, s_rdat
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr,
    output m_wdat, m_cti, m_bte,
    input  m_ack, m_err, m_rty, m_rdat
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr,
    input  s_wdat, s_cti, s_bte,
    output s_ack, s_err, s_rty, s_rdat
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter, grant held for the whole
// CYC cycle, with a watchdog that aborts stalled slave strobes via ERR.
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_rr_arbiter_if.arb    bus,
  output logic            owner_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } state_t;

  localparam logic [7:0] WD_LAST =
    8'(TIMEOUT_CYCLES - 1);

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   last, last_nx;
  logic   err_pend, err_pend_nx;
  logic   [7:0] wd_cnt, wd_nx;
  logic   winner;

  logic   own_cyc, own_stb, stb_on;
  logic   term, expire;

  logic [ADDR_WIDTH-1:0] adr_mux;
  logic [DATA_WIDTH-1:0] wdat_mux;

  assign own_cyc  = bus.m_cyc[owner];
  assign own_stb  = bus.m_stb[owner];
  assign stb_on   = own_cyc & own_stb;
  assign adr_mux  = bus.m_adr[owner];
  assign wdat_mux = bus.m_wdat[owner];
  assign term     = bus.s_ack | bus.s_err
                  | bus.s_rty;

  // A termination in the expiry cycle wins.
  assign expire = (TIMEOUT_CYCLES != 0)
                && (wd_cnt == WD_LAST)
                && stb_on && !term;

  assign bus.m_rdat[0] = bus.s_rdat;
  assign bus.m_rdat[1] = bus.s_rdat;
  assign owner_o       = owner;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      wd_cnt   <= '0;
      err_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      wd_cnt   <= wd_nx;
      err_pend <= err_pend_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    wd_nx       = '0;
    err_pend_nx = 1'b0;
    winner      = 1'b0;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_wdat  = '0;
    bus.s_cti   = '0;
    bus.s_bte   = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_rty   = '0;
    unique case (state)
      IDLE: begin
        if (|bus.m_cyc) begin
          winner   = (&bus.m_cyc) ? ~last
                                  : bus.m_cyc[1];
          owner_nx = winner;
          last_nx  = winner;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        bus.s_cyc  = own_cyc;
        bus.s_stb  = stb_on;
        bus.s_we   = bus.m_we[owner];
        bus.s_adr  = adr_mux;
        bus.s_wdat = wdat_mux;
        bus.s_cti  = bus.m_cti[owner];
        bus.s_bte  = bus.m_bte[owner];
        bus.m_ack[owner] = bus.s_ack & own_cyc;
        bus.m_err[owner] = bus.s_err & own_cyc;
        bus.m_rty[owner] = bus.s_rty & own_cyc;
        if (!own_cyc) begin
          state_nx = IDLE;
        end else if (expire) begin
          state_nx    = ABORT;
          err_pend_nx = 1'b1;
        end else if (stb_on && !term) begin
          wd_nx = wd_cnt + 8'd1;
        end
      end
      ABORT: begin
        bus.m_err[owner] = err_pend;
        if (!own_cyc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed master traffic pushes
// expected grants/terminations, a negedge monitor pops and compares.
module tb_wb_rr_arbiter;
  localparam int AW = 23;
  localparam int DW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner;
  int   cyc_n = 0;
  int   ack_delay = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_cyc = 1'b0;

  typedef struct {
    int         kind;
    int         mst;
    logic [7:0] dat;
    logic [22:0] adr;
    logic [2:0] cti;
    logic [1:0] bte;
    int         cyc;
  } exp_t;

  exp_t q[$];

  wb_rr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .owner_o(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chk(string nm,
      longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, exp, cyc_n);
    end
  endfunction

  function automatic void push(int k, int m,
      logic [22:0] a, logic [2:0] cti,
      logic [1:0] bte, int c);
    exp_t e;
    e.kind = k;
    e.mst  = m;
    e.adr  = a;
    e.dat  = a[7:0] ^ 8'hA5;
    e.cti  = cti;
    e.bte  = bte;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  function automatic void observe(int k, int m);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: kind %0d m%0d @cyc %0d",
               k, m, cyc_n);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", k, e.kind);
    chk("ev_master", m, e.mst);
    if (e.cyc >= 0) chk("ev_cycle", cyc_n, e.cyc);
    if (k == 1) begin
      chk("rdat", bus.m_rdat[m], e.dat);
      chk("s_adr", bus.s_adr, e.adr);
      chk("s_cti", bus.s_cti, e.cti);
      chk("s_bte", bus.s_bte, e.bte);
    end
    if (k == 2) begin
      chk("abort_s_cyc", bus.s_cyc, 0);
      chk("abort_s_stb", bus.s_stb, 0);
    end
  endfunction

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cyc = 1'b0;
      end else begin
        if (bus.s_cyc && !prev_cyc)
          observe(0, int'(owner));
        for (int i = 0; i < 2; i++) begin
          if (bus.m_ack[i]) observe(1, i);
          if (bus.m_err[i]) observe(2, i);
          if (bus.m_rty[i]) observe(3, i);
        end
        prev_cyc = bus.s_cyc;
      end
    end
  end

  // slave: ack after ack_delay stalled cycles; adr[22] region hangs
  initial begin
    int wcnt;
    wcnt = 0;
    bus.s_ack  = 1'b0;
    bus.s_err  = 1'b0;
    bus.s_rty  = 1'b0;
    bus.s_rdat = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        bus.s_ack = 1'b0;
        wcnt = 0;
      end else if (bus.s_ack) begin
        bus.s_ack = 1'b0;
        wcnt = 0;
      end else if (bus.s_cyc && bus.s_stb
                   && !bus.s_adr[22]) begin
        if (wcnt >= ack_delay) begin
          bus.s_ack  = 1'b1;
          bus.s_rdat = bus.s_adr[7:0] ^ 8'hA5;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic drv(int i, logic cyc, logic stb,
      logic we, logic [22:0] a, logic [2:0] cti,
      logic [1:0] bte);
    bus.m_cyc[i]  = cyc;
    bus.m_stb[i]  = stb;
    bus.m_we[i]   = we;
    bus.m_adr[i]  = a;
    bus.m_wdat[i] = a[7:0];
    bus.m_cti[i]  = cti;
    bus.m_bte[i]  = bte;
  endtask

  // called at posedge+1; returns at posedge+1 with CYC dropped
  task automatic run_master(int i, int n,
      logic burst, logic we, logic [22:0] base,
      logic [1:0] bte);
    for (int b = 0; b < n; b++) begin
      logic [2:0] cti;
      bit done;
      bit was_err;
      int t;
      cti = !burst ? 3'b000
          : (b == n - 1) ? 3'b111 : 3'b010;
      done = 0;
      was_err = 0;
      t = 0;
      drv(i, 1'b1, 1'b1, we, base + 23'(b), cti, bte);
      while (!done) begin
        @(negedge clk);
        if (bus.m_ack[i] || bus.m_err[i]
            || bus.m_rty[i]) begin
          done = 1;
          was_err = bus.m_err[i];
        end else if (++t > 60) begin
          chk($sformatf("m%0d_wait_timeout", i), t, 0);
          done = 1;
          was_err = 1;
        end
      end
      @(posedge clk);
      #1;
      if (was_err) b = n;
    end
    drv(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic master_seq(int i, int ncyc,
      int nbeat, logic [22:0] base);
    for (int k = 0; k < ncyc; k++) begin
      run_master(i, nbeat, 1'b0, 1'b0,
                 base + 23'(16 * k), 2'b00);
      if (k < ncyc - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int g;
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #12;
    chk("rst_owner", owner, 0);
    chk("rst_s_cyc", bus.s_cyc, 0);
    chk("rst_s_stb", bus.s_stb, 0);
    chk("rst_m_ack", bus.m_ack, 0);
    chk("rst_m_err", bus.m_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();

    // single read, ack after 3 stall cycles
    ack_delay = 3;
    g = cyc_n + 1;
    push(0, 0, '0, '0, '0, g);
    push(1, 0, 23'h000000, 3'b000, 2'b00, g + 3);
    run_master(0, 1, 1'b0, 1'b0, 23'h000000, 2'b00);
    settle();

    // tie from reset: m0, m1, m0, m1
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    settle();
    ack_delay = 1;
    g = cyc_n + 1;
    push(0, 0, '0, '0, '0, g);
    push(1, 0, 23'h000100, 3'b000, 2'b00, -1);
    push(1, 0, 23'h000101, 3'b000, 2'b00, -1);
    push(0, 1, '0, '0, '0, g + 7);
    push(1, 1, 23'h000200, 3'b000, 2'b00, -1);
    push(1, 1, 23'h000201, 3'b000, 2'b00, -1);
    push(0, 0, '0, '0, '0, g + 14);
    push(1, 0, 23'h000110, 3'b000, 2'b00, -1);
    push(1, 0, 23'h000111, 3'b000, 2'b00, -1);
    push(0, 1, '0, '0, '0, g + 21);
    push(1, 1, 23'h000210, 3'b000, 2'b00, -1);
    push(1, 1, 23'h000211, 3'b000, 2'b00, -1);
    fork
      master_seq(0, 2, 2, 23'h000100);
      master_seq(1, 2, 2, 23'h000200);
    join
    settle();

    // m1 burst, m0 waits for the whole CYC
    ack_delay = 0;
    g = cyc_n + 1;
    push(0, 1, '0, '0, '0, g);
    push(1, 1, 23'h000300, 3'b010, 2'b01, g);
    push(1, 1, 23'h000301, 3'b010, 2'b01, g + 2);
    push(1, 1, 23'h000302, 3'b010, 2'b01, g + 4);
    push(1, 1, 23'h000303, 3'b111, 2'b01, g + 6);
    push(0, 0, '0, '0, '0, g + 9);
    push(1, 0, 23'h000040, 3'b000, 2'b00, g + 9);
    fork
      run_master(1, 4, 1'b1, 1'b0, 23'h000300, 2'b01);
      begin
        @(posedge clk);
        #1;
        run_master(0, 1, 1'b0, 1'b0, 23'h000040, 2'b00);
      end
    join
    settle();

    // watchdog abort on hung slave, m1 served after
    g = cyc_n + 1;
    push(0, 0, '0, '0, '0, g);
    push(2, 0, '0, '0, '0, g + 8);
    push(0, 1, '0, '0, '0, g + 11);
    push(1, 1, 23'h000077, 3'b000, 2'b00, g + 11);
    fork
      run_master(0, 1, 1'b0, 1'b0, 23'h400000, 2'b00);
      begin
        @(posedge clk);
        #1;
        run_master(1, 1, 1'b0, 1'b0, 23'h000077, 2'b00);
      end
    join
    settle();

    // ack lands on the expiry cycle: no abort
    ack_delay = 7;
    g = cyc_n + 1;
    push(0, 0, '0, '0, '0, g);
    push(1, 0, 23'h000055, 3'b000, 2'b00, g + 7);
    run_master(0, 1, 1'b0, 1'b0, 23'h000055, 2'b00);
    settle();

    // async reset during a busy write
    ack_delay = 0;
    g = cyc_n + 1;
    push(0, 0, '0, '0, '0, g);
    drv(0, 1'b1, 1'b1, 1'b1, 23'h400010, 3'b000, 2'b00);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", bus.s_cyc, 0);
    chk("arst_s_stb", bus.s_stb, 0);
    chk("arst_s_we", bus.s_we, 0);
    chk("arst_s_adr", bus.s_adr, 0);
    chk("arst_owner", owner, 0);
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    g = cyc_n + 1;
    push(0, 1, '0, '0, '0, g);
    push(1, 1, 23'h000066, 3'b000, 2'b00, g);
    run_master(1, 1, 1'b0, 1'b0, 23'h000066, 2'b00);
    settle();

    repeat (5) @(posedge clk);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
